// File: rtl/eval_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eval_buffer_pkg
//  Description : Shared helpers for the evaluation-fabric elastic buffers:
//                counter/pointer width sizing and circular pointer increment
//                that also works for queue depths that are not powers of two.
//  Revision    : 1.0  initial release
// ============================================================================
package eval_buffer_pkg;

    // Pointers are at least one bit wide, even for a single-entry queue.
    localparam int unsigned c_min_ptr_width = 1;

    // Width needed to hold an occupancy from 0 to depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to index depth entries.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : c_min_ptr_width;
    endfunction

    // Advance a circular pointer, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eval_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : eval_elastic_buffer
//  Description : WIDTH-bit, DEPTH-entry circular-queue elastic buffer with
//                valid/ready on both sides. FLOW=1 adds a zero-latency
//                bypass from enqueue to dequeue while the queue is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module eval_elastic_buffer
    import eval_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FLOW  = 0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [WIDTH-1:0]               enq_bits,
    output logic                           deq_valid,
    input  logic                           deq_ready,
    output logic [WIDTH-1:0]               deq_bits,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int unsigned c_cnt_w = count_width(DEPTH);
    localparam int unsigned c_ptr_w = ptr_width(DEPTH);
    localparam bit          c_flow  = (FLOW != 0);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_enq_fire;
    logic w_store;
    logic w_deq_store;

    // Ready depends only on stored occupancy, so there is no path from deq_ready.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cnt_w'(DEPTH));
    assign enq_ready  = !w_full;

    // In FLOW mode an empty queue forwards the producer straight to the consumer.
    assign deq_valid  = !w_empty || (c_flow && enq_valid);
    assign deq_bits   = (c_flow && w_empty) ? enq_bits : r_mem[r_rd_ptr];

    // A bypassed item is consumed in flight and never touches storage.
    assign w_bypass    = c_flow && w_empty && enq_valid && deq_ready;
    assign w_enq_fire  = enq_valid && enq_ready;
    assign w_store     = w_enq_fire && !w_bypass;
    assign w_deq_store = deq_valid && deq_ready && !w_empty;

    assign count = r_count;

    // Payload storage: written on stored enqueues only; contents are not reset.
    always_ff @(posedge clock) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= enq_bits;
        end
    end

    // Pointer and occupancy bookkeeping; a reset discards everything stored.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= c_ptr_w'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_deq_store) begin
                r_rd_ptr <= c_ptr_w'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            case ({w_store, w_deq_store})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eval_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eval_elastic_buffer
//  Description : Self-checking bench for eval_elastic_buffer. Three instances:
//                A (8b, depth 4, registered), B (8b, depth 3, registered),
//                C (8b, depth 4, FLOW bypass). Per-instance scoreboards check
//                dequeue order; directed checks cover occupancy and timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eval_elastic_buffer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: WIDTH=8, DEPTH=4, FLOW=0
    logic       a_enq_valid, a_enq_ready, a_deq_valid, a_deq_ready;
    logic [7:0] a_enq_bits, a_deq_bits;
    logic [2:0] a_count;
    // Instance B: WIDTH=8, DEPTH=3, FLOW=0
    logic       b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready;
    logic [7:0] b_enq_bits, b_deq_bits;
    logic [1:0] b_count;
    // Instance C: WIDTH=8, DEPTH=4, FLOW=1
    logic       c_enq_valid, c_enq_ready, c_deq_valid, c_deq_ready;
    logic [7:0] c_enq_bits, c_deq_bits;
    logic [2:0] c_count;

    eval_elastic_buffer #(.WIDTH(8), .DEPTH(4), .FLOW(0)) u_a (
        .clock(clk), .reset_n(reset_n),
        .enq_valid(a_enq_valid), .enq_ready(a_enq_ready), .enq_bits(a_enq_bits),
        .deq_valid(a_deq_valid), .deq_ready(a_deq_ready), .deq_bits(a_deq_bits),
        .count(a_count)
    );
    eval_elastic_buffer #(.WIDTH(8), .DEPTH(3), .FLOW(0)) u_b (
        .clock(clk), .reset_n(reset_n),
        .enq_valid(b_enq_valid), .enq_ready(b_enq_ready), .enq_bits(b_enq_bits),
        .deq_valid(b_deq_valid), .deq_ready(b_deq_ready), .deq_bits(b_deq_bits),
        .count(b_count)
    );
    eval_elastic_buffer #(.WIDTH(8), .DEPTH(4), .FLOW(1)) u_c (
        .clock(clk), .reset_n(reset_n),
        .enq_valid(c_enq_valid), .enq_ready(c_enq_ready), .enq_bits(c_enq_bits),
        .deq_valid(c_deq_valid), .deq_ready(c_deq_ready), .deq_bits(c_deq_bits),
        .count(c_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboards: accepted payloads queued, popped in order on each dequeue.
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [7:0] c_q[$];

    // Monitor: samples handshakes at the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            a_q.delete();
            b_q.delete();
            c_q.delete();
        end else begin
            if (a_enq_valid && a_enq_ready) a_q.push_back(a_enq_bits);
            if (b_enq_valid && b_enq_ready) b_q.push_back(b_enq_bits);
            if (c_enq_valid && c_enq_ready) c_q.push_back(c_enq_bits);
            if (a_deq_valid && a_deq_ready) begin
                if (a_q.size() == 0) chk("a_unexpected_deq", 32'(a_deq_bits), 32'hFFFF_FFFF);
                else                 chk("a_deq_order", 32'(a_deq_bits), 32'(a_q.pop_front()));
            end
            if (b_deq_valid && b_deq_ready) begin
                if (b_q.size() == 0) chk("b_unexpected_deq", 32'(b_deq_bits), 32'hFFFF_FFFF);
                else                 chk("b_deq_order", 32'(b_deq_bits), 32'(b_q.pop_front()));
            end
            if (c_deq_valid && c_deq_ready) begin
                if (c_q.size() == 0) chk("c_unexpected_deq", 32'(c_deq_bits), 32'hFFFF_FFFF);
                else                 chk("c_deq_order", 32'(c_deq_bits), 32'(c_q.pop_front()));
            end
        end
    end

    // Advance to just after the next rising edge, ready to drive new inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] push_data [5];

    initial begin
        reset_n = 1'b0;
        a_enq_valid = 1'b0; a_enq_bits = '0; a_deq_ready = 1'b0;
        b_enq_valid = 1'b0; b_enq_bits = '0; b_deq_ready = 1'b0;
        c_enq_valid = 1'b0; c_enq_bits = '0; c_deq_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #3;

        // Reset then idle.
        chk("a_reset_count", 32'(a_count), 0);
        chk("a_reset_enq_ready", 32'(a_enq_ready), 1);
        chk("a_reset_deq_valid", 32'(a_deq_valid), 0);
        chk("c_reset_count", 32'(c_count), 0);

        // Fill A to DEPTH, fifth push refused.
        push_data[0] = 8'h11; push_data[1] = 8'h22; push_data[2] = 8'h33;
        push_data[3] = 8'h44; push_data[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            cyc();
            a_enq_valid = 1'b1;
            a_enq_bits  = push_data[i];
            #3;
            chk("a_fill_count", 32'(a_count), 32'(i < 4 ? i : 4));
            chk("a_fill_enq_ready", 32'(a_enq_ready), 32'(i < 4 ? 1 : 0));
        end
        // Drain A: 0x11..0x44 in order.
        for (int i = 0; i < 4; i++) begin
            cyc();
            a_enq_valid = 1'b0;
            a_deq_ready = 1'b1;
            #3;
            chk("a_drain_count", 32'(a_count), 32'(4 - i));
            chk("a_drain_bits", 32'(a_deq_bits), 32'(push_data[i]));
        end
        cyc();
        a_deq_ready = 1'b0;
        #3;
        chk("a_drained_count", 32'(a_count), 0);
        chk("a_drained_deq_valid", 32'(a_deq_valid), 0);

        // DEPTH=3 streaming with a counter payload across pointer wrap.
        for (int k = 0; k <= 20; k++) begin
            cyc();
            b_enq_valid = 1'b1;
            b_enq_bits  = 8'(k);
            b_deq_ready = 1'b1;
            #3;
            if (k == 0) begin
                chk("b_stream_first_empty", 32'(b_deq_valid), 0);
            end else begin
                chk("b_stream_count", 32'(b_count), 1);
                chk("b_stream_bits", 32'(b_deq_bits), 32'(k - 1));
            end
        end
        cyc();
        b_enq_valid = 1'b0;
        #3;
        chk("b_tail_bits", 32'(b_deq_bits), 20);
        cyc();
        b_deq_ready = 1'b0;
        #3;
        chk("b_tail_count", 32'(b_count), 0);

        // Full with deq_ready: dequeue fires, enqueue waits a cycle.
        for (int i = 0; i < 4; i++) begin
            cyc();
            a_enq_valid = 1'b1;
            a_enq_bits  = 8'(i + 1);
        end
        cyc();
        a_enq_bits  = 8'h05;
        a_deq_ready = 1'b1;
        #3;
        chk("a_full_count", 32'(a_count), 4);
        chk("a_full_enq_ready", 32'(a_enq_ready), 0);
        chk("a_full_deq_bits", 32'(a_deq_bits), 32'h01);
        cyc();
        #3;
        chk("a_after_full_count", 32'(a_count), 3);
        chk("a_after_full_enq_ready", 32'(a_enq_ready), 1);
        cyc();
        a_enq_valid = 1'b0;
        #3;
        chk("a_refill_count", 32'(a_count), 3);
        chk("a_refill_bits", 32'(a_deq_bits), 32'h03);
        for (int i = 0; i < 3; i++) cyc();
        a_deq_ready = 1'b0;
        #3;
        chk("a_full_drain_count", 32'(a_count), 0);

        // FLOW=1 bypass when empty.
        cyc();
        c_enq_valid = 1'b1;
        c_enq_bits  = 8'hA5;
        c_deq_ready = 1'b1;
        #3;
        chk("c_bypass_deq_valid", 32'(c_deq_valid), 1);
        chk("c_bypass_deq_bits", 32'(c_deq_bits), 32'hA5);
        chk("c_bypass_count", 32'(c_count), 0);
        cyc();
        c_deq_ready = 1'b0;
        #3;
        chk("c_bypass_not_stored", 32'(c_count), 0);
        chk("c_flow_deq_valid", 32'(c_deq_valid), 1);
        cyc();
        c_enq_valid = 1'b0;
        #3;
        chk("c_stored_count", 32'(c_count), 1);
        chk("c_stored_bits", 32'(c_deq_bits), 32'hA5);
        cyc();
        c_deq_ready = 1'b1;
        cyc();
        c_deq_ready = 1'b0;
        #3;
        chk("c_drained_count", 32'(c_count), 0);

        // Reset mid-operation discards stored entries.
        for (int i = 0; i < 3; i++) begin
            cyc();
            a_enq_valid = 1'b1;
            a_enq_bits  = 8'(8'h21 + i);
        end
        cyc();
        a_enq_valid = 1'b0;
        #3;
        chk("a_prereset_count", 32'(a_count), 3);
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #3;
        chk("a_postreset_count", 32'(a_count), 0);
        chk("a_postreset_deq_valid", 32'(a_deq_valid), 0);
        cyc();
        a_enq_valid = 1'b1;
        a_enq_bits  = 8'h7E;
        cyc();
        a_enq_valid = 1'b0;
        a_deq_ready = 1'b1;
        #3;
        chk("a_postreset_first", 32'(a_deq_bits), 32'h7E);
        cyc();
        a_deq_ready = 1'b0;
        #3;
        chk("a_final_count", 32'(a_count), 0);

        // Nothing accepted may remain undelivered.
        chk("a_sb_empty", 32'(a_q.size()), 0);
        chk("b_sb_empty", 32'(b_q.size()), 0);
        chk("c_sb_empty", 32'(c_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
